game_controller: RTL and testbench



---
 rtl/game_pkg.sv | 30 +++
 rtl/frame_timer.sv | 37 +++
 rtl/game_controller.sv | 165 ++++++++++++++++
 tb/tb_game_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
//==============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the game sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package game_pkg;

    localparam int LIVES_WIDTH = 2;

    localparam logic [8:0] KEY_START = 9'h05A;
    localparam logic [8:0] KEY_PAUSE = 9'h04D;

    // Encoding 3'd4 stays reserved for PAUSED even when pausing is not built.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INTRO  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_HIT    = 3'd3,
`ifdef GAME_PAUSE_KEY_EN
        ST_PAUSED = 3'd4,
`endif
        ST_OVER   = 3'd5,
        ST_WIN    = 3'd6
    } game_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
//==============================================================================
// Module      : frame_timer
// Description : Saturating startOfFrame counter with clear and limit flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_timer #(
    parameter int LIMIT = 120
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic last_o,
    output logic done_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            count_q <= '0;
        end else if (count_i && (count_q != W'(LIMIT))) begin
            count_q <= count_q + W'(1);
        end
    end

    // While clearing, the held count belongs to the previous state and is not trusted.
    assign last_o = count_i && !clear_i && (count_q == W'(LIMIT - 1));
    assign done_o = !clear_i && (count_q == W'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
//==============================================================================
// Module      : game_controller
// Description : Game phase, lives and level sequencer gating play movement.
//               Optional pause key support under macro GAME_PAUSE_KEY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module game_controller
    import game_pkg::*;
#(
    parameter int                       LIVES_INIT    = 3,
    parameter int                       LEVEL_MAX     = 4,
    parameter int                       PAUSE_FRAMES  = 120,
    parameter int                       KEYCODE_WIDTH = 9,
    parameter logic [KEYCODE_WIDTH-1:0] START_KEY     = KEYCODE_WIDTH'(KEY_START),
    parameter logic [KEYCODE_WIDTH-1:0] PAUSE_KEY     = KEYCODE_WIDTH'(KEY_PAUSE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         startOfFrame,
    input  logic [KEYCODE_WIDTH-1:0]     keyCode,
    input  logic                         make,
    input  logic                         player_hit,
    input  logic                         monsters_cleared,
    input  logic                         monsters_landed,
    output logic [2:0]                   game_state,
    output logic                         game_en,
    output logic                         level_start,
    output logic [$clog2(LEVEL_MAX)-1:0] level,
    output logic [LIVES_WIDTH-1:0]       lives
);

    localparam int                     LW         = $clog2(LEVEL_MAX);
    localparam logic [LW-1:0]          LEVEL_LAST = LW'(LEVEL_MAX - 1);
    localparam logic [LIVES_WIDTH-1:0] LIVES_LOAD = LIVES_WIDTH'(LIVES_INIT);

    game_state_t            state_q;
    logic                   game_en_q;
    logic                   level_start_q;
    logic [LW-1:0]          level_q;
    logic [LIVES_WIDTH-1:0] lives_q;
    logic                   entry_q;

    logic w_start_key;
    logic w_new_game;
    logic w_timer_last;
    logic w_timer_done;

    assign w_start_key = make && (keyCode == START_KEY);

`ifdef GAME_PAUSE_KEY_EN
    logic w_pause_key;
    assign w_pause_key = make && (keyCode == PAUSE_KEY);
`else
    logic w_unused_pause;
    assign w_unused_pause = make && (keyCode == PAUSE_KEY);
`endif

    // OVER/WIN accept a restart only after their full pause has elapsed.
    assign w_new_game = w_start_key &&
                        ((state_q == ST_IDLE) ||
                         (((state_q == ST_OVER) || (state_q == ST_WIN)) && w_timer_done));

    // entry_q marks the first cycle of a timed state: the timer clears and ignores that pulse.
    frame_timer #(
        .LIMIT (PAUSE_FRAMES)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (entry_q),
        .count_i (startOfFrame),
        .last_o  (w_timer_last),
        .done_o  (w_timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            game_en_q     <= 1'b0;
            level_start_q <= 1'b0;
            level_q       <= '0;
            lives_q       <= '0;
            entry_q       <= 1'b0;
        end else begin
            level_start_q <= 1'b0;
            entry_q       <= 1'b0;
            if (w_new_game) begin
                state_q       <= ST_INTRO;
                game_en_q     <= 1'b0;
                lives_q       <= LIVES_LOAD;
                level_q       <= '0;
                level_start_q <= 1'b1;
                entry_q       <= 1'b1;
            end else begin
                case (state_q)
                    ST_INTRO, ST_HIT: begin
                        if (w_timer_last) begin
                            state_q   <= ST_PLAY;
                            game_en_q <= 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (monsters_landed) begin
                            state_q   <= ST_OVER;
                            lives_q   <= '0;
                            game_en_q <= 1'b0;
                            entry_q   <= 1'b1;
                        end else if (player_hit) begin
                            game_en_q <= 1'b0;
                            entry_q   <= 1'b1;
                            if (lives_q <= LIVES_WIDTH'(1)) begin
                                state_q <= ST_OVER;
                                lives_q <= '0;
                            end else begin
                                state_q <= ST_HIT;
                                lives_q <= lives_q - LIVES_WIDTH'(1);
                            end
                        end else if (monsters_cleared) begin
                            game_en_q <= 1'b0;
                            entry_q   <= 1'b1;
                            if (level_q == LEVEL_LAST) begin
                                state_q <= ST_WIN;
                            end else begin
                                state_q       <= ST_INTRO;
                                level_q       <= level_q + LW'(1);
                                level_start_q <= 1'b1;
                            end
                        end
`ifdef GAME_PAUSE_KEY_EN
                        else if (w_pause_key) begin
                            state_q   <= ST_PAUSED;
                            game_en_q <= 1'b0;
                        end
`endif
                    end
`ifdef GAME_PAUSE_KEY_EN
                    ST_PAUSED: begin
                        if (w_pause_key) begin
                            state_q   <= ST_PLAY;
                            game_en_q <= 1'b1;
                        end
                    end
`endif
                    ST_IDLE, ST_OVER, ST_WIN: begin
                        game_en_q <= 1'b0;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        game_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign game_state  = state_q;
    assign game_en     = game_en_q;
    assign level_start = level_start_q;
    assign level       = level_q;
    assign lives       = lives_q;

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
//==============================================================================
// Module      : tb_game_controller
// Description : Directed scoreboard bench for game_controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_game_controller;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INTRO  = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_HIT    = 3'd3;
`ifdef GAME_PAUSE_KEY_EN
    localparam logic [2:0] S_PAUSED = 3'd4;
`endif
    localparam logic [2:0] S_OVER   = 3'd5;
    localparam logic [2:0] S_WIN    = 3'd6;

    localparam logic [8:0] K_START = 9'h05A;
    localparam logic [8:0] K_PAUSE = 9'h04D;
    localparam logic [8:0] K_OTHER = 9'h01C;

    logic       clk = 1'b0;
    logic       rst;
    logic       startOfFrame;
    logic [8:0] keyCode;
    logic       make;
    logic       player_hit;
    logic       monsters_cleared;
    logic       monsters_landed;
    logic [2:0] game_state;
    logic       game_en;
    logic       level_start;
    logic [1:0] level;
    logic [1:0] lives;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  tests = 0;
    int  fails = 0;

    game_controller dut (
        .clk              (clk),
        .rst              (rst),
        .startOfFrame     (startOfFrame),
        .keyCode          (keyCode),
        .make             (make),
        .player_hit       (player_hit),
        .monsters_cleared (monsters_cleared),
        .monsters_landed  (monsters_landed),
        .game_state       (game_state),
        .game_en          (game_en),
        .level_start      (level_start),
        .level            (level),
        .lives            (lives)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_next();
        sb_t        e;
        logic [8:0] obs;
        obs = {game_state, game_en, level_start, level, lives};
        tests++;
        assert (sb_q.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s: observed state=%0d en=%0b ls=%0b level=%0d lives=%0d, expected state=%0d en=%0b ls=%0b level=%0d lives=%0d",
                       e.tag, obs[8:6], obs[5], obs[4], obs[3:2], obs[1:0],
                       e.exp[8:6], e.exp[5], e.exp[4], e.exp[3:2], e.exp[1:0]);
            end
        end
    endtask

    // Push the expected post-edge snapshot, clock once, then compare.
    task automatic step(input string tag, input logic [2:0] st, input logic en,
                        input logic ls, input logic [1:0] lvl, input logic [1:0] lv);
        sb_t e;
        e.tag = tag;
        e.exp = {st, en, ls, lvl, lv};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_next();
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            @(posedge clk);
            #1;
            startOfFrame = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [8:0] k);
        keyCode = k;
        make    = 1'b1;
    endtask

    // Called in the entry cycle of INTRO/HIT; walks the full pause into PLAY.
    task automatic timed_to_play(input string tag, input logic [2:0] st,
                                 input logic [1:0] lvl, input logic [1:0] lv);
        step({tag, "_entry"}, st, 1'b0, 1'b0, lvl, lv);
        frames(119);
        step({tag, "_119"}, st, 1'b0, 1'b0, lvl, lv);
        startOfFrame = 1'b1;
        step({tag, "_play"}, S_PLAY, 1'b1, 1'b0, lvl, lv);
        startOfFrame = 1'b0;
    endtask

    initial begin
        rst = 1'b1; startOfFrame = 1'b0; keyCode = '0; make = 1'b0;
        player_hit = 1'b0; monsters_cleared = 1'b0; monsters_landed = 1'b0;
        @(posedge clk);
        #1;
        step("reset", S_IDLE, 1'b0, 1'b0, 2'd0, 2'd0);
        rst = 1'b0;

        // New game and key qualification
        press(K_OTHER);
        step("bad_key", S_IDLE, 1'b0, 1'b0, 2'd0, 2'd0);
        make = 1'b0; keyCode = K_START;
        step("key_no_make", S_IDLE, 1'b0, 1'b0, 2'd0, 2'd0);
        press(K_START);
        step("start", S_INTRO, 1'b0, 1'b1, 2'd0, 2'd3);
        make = 1'b0;
        player_hit = 1'b1; monsters_landed = 1'b1;
        step("intro_events_ignored", S_INTRO, 1'b0, 1'b0, 2'd0, 2'd3);
        player_hit = 1'b0; monsters_landed = 1'b0;
        frames(119);
        step("intro_119", S_INTRO, 1'b0, 1'b0, 2'd0, 2'd3);
        startOfFrame = 1'b1;
        step("intro_play", S_PLAY, 1'b1, 1'b0, 2'd0, 2'd3);
        startOfFrame = 1'b0;

        // Losing lives; a pulse in the HIT entry cycle must not count
        player_hit = 1'b1;
        step("hit1", S_HIT, 1'b0, 1'b0, 2'd0, 2'd2);
        player_hit = 1'b0;
        startOfFrame = 1'b1;
        step("hit1_entry_pulse", S_HIT, 1'b0, 1'b0, 2'd0, 2'd2);
        startOfFrame = 1'b0;
        frames(119);
        step("hit1_119", S_HIT, 1'b0, 1'b0, 2'd0, 2'd2);
        startOfFrame = 1'b1;
        step("hit1_play", S_PLAY, 1'b1, 1'b0, 2'd0, 2'd2);
        startOfFrame = 1'b0;
        player_hit = 1'b1;
        step("hit2", S_HIT, 1'b0, 1'b0, 2'd0, 2'd1);
        player_hit = 1'b0;
        timed_to_play("hit2", S_HIT, 2'd0, 2'd1);
        player_hit = 1'b1;
        step("hit3_over", S_OVER, 1'b0, 1'b0, 2'd0, 2'd0);
        player_hit = 1'b0;

        // Start-key lockout in OVER
        step("over_entry", S_OVER, 1'b0, 1'b0, 2'd0, 2'd0);
        frames(50);
        press(K_START);
        step("over_lock_50", S_OVER, 1'b0, 1'b0, 2'd0, 2'd0);
        make = 1'b0;
        frames(69);
        press(K_START);
        step("over_lock_119", S_OVER, 1'b0, 1'b0, 2'd0, 2'd0);
        make = 1'b0;
        frames(1);
        press(K_START);
        step("over_restart", S_INTRO, 1'b0, 1'b1, 2'd0, 2'd3);
        make = 1'b0;

        // Level progression to WIN
        timed_to_play("lvl0", S_INTRO, 2'd0, 2'd3);
        for (int l = 0; l < 3; l++) begin
            monsters_cleared = 1'b1;
            step("cleared", S_INTRO, 1'b0, 1'b1, 2'(l + 1), 2'd3);
            monsters_cleared = 1'b0;
            timed_to_play("lvl_up", S_INTRO, 2'(l + 1), 2'd3);
        end
        monsters_cleared = 1'b1;
        step("win", S_WIN, 1'b0, 1'b0, 2'd3, 2'd3);
        monsters_cleared = 1'b0;
        step("win_hold", S_WIN, 1'b0, 1'b0, 2'd3, 2'd3);
        frames(120);
        press(K_START);
        step("win_restart", S_INTRO, 1'b0, 1'b1, 2'd0, 2'd3);
        make = 1'b0;

        // Event priority
        timed_to_play("g2", S_INTRO, 2'd0, 2'd3);
        monsters_cleared = 1'b1;
        step("g2_cleared", S_INTRO, 1'b0, 1'b1, 2'd1, 2'd3);
        monsters_cleared = 1'b0;
        timed_to_play("g2_l1", S_INTRO, 2'd1, 2'd3);
        player_hit = 1'b1; monsters_cleared = 1'b1;
        step("hit_beats_clear", S_HIT, 1'b0, 1'b0, 2'd1, 2'd2);
        player_hit = 1'b0; monsters_cleared = 1'b0;
        timed_to_play("g2_hit", S_HIT, 2'd1, 2'd2);
        player_hit = 1'b1; monsters_cleared = 1'b1; monsters_landed = 1'b1;
        step("simultaneous", S_OVER, 1'b0, 1'b0, 2'd1, 2'd0);
        player_hit = 1'b0; monsters_cleared = 1'b0; monsters_landed = 1'b0;
        step("over2_entry", S_OVER, 1'b0, 1'b0, 2'd1, 2'd0);
        frames(120);
        press(K_START);
        step("over2_restart", S_INTRO, 1'b0, 1'b1, 2'd0, 2'd3);
        make = 1'b0;
        timed_to_play("g3", S_INTRO, 2'd0, 2'd3);

        // Pause key
        press(K_PAUSE);
`ifdef GAME_PAUSE_KEY_EN
        step("pause", S_PAUSED, 1'b0, 1'b0, 2'd0, 2'd3);
        make = 1'b0;
        player_hit = 1'b1;
        step("paused_hit_ignored", S_PAUSED, 1'b0, 1'b0, 2'd0, 2'd3);
        player_hit = 1'b0;
        press(K_PAUSE);
        step("unpause", S_PLAY, 1'b1, 1'b0, 2'd0, 2'd3);
        make = 1'b0;
`else
        step("pause_key_ignored", S_PLAY, 1'b1, 1'b0, 2'd0, 2'd3);
        make = 1'b0;
`endif

        // Reset mid-INTRO discards the pending level_start pulse
        monsters_cleared = 1'b1;
        step("g3_cleared", S_INTRO, 1'b0, 1'b1, 2'd1, 2'd3);
        monsters_cleared = 1'b0;
        rst = 1'b1;
        step("mid_reset", S_IDLE, 1'b0, 1'b0, 2'd0, 2'd0);
        rst = 1'b0;
        step("post_reset", S_IDLE, 1'b0, 1'b0, 2'd0, 2'd0);
        press(K_START);
        step("post_reset_start", S_INTRO, 1'b0, 1'b1, 2'd0, 2'd3);
        make = 1'b0;
        timed_to_play("g4", S_INTRO, 2'd0, 2'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
